shift_pipe: RTL

- Parametrised, pipelined shift/rotate execution unit for the backend execute stage; successor to the single-cycle shift unit.
- Accepts one op per cycle under valid/ready, with downstream backpressure and pipeline flush.
- Adds ROL/ROR, correct RV64 W-variant sign extension, configurable XLEN and pipeline depth.
- Carries the renamed destination tag alongside the result to the writeback arbiter.

---
 rtl/shift_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit: the shift amount is consumed a few bits per stage,
// and W-op sign extension plus illegal-op zeroing happen in the final stage.
module shift_pipe #(
    parameter int XLEN   = 64,
    parameter int RB     = 2,
    parameter int STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_is32w,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [4+RB:0]   in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [4+RB:0]   out_rd
);

    localparam int RDW = 5 + RB;

    // Shift-amount bits handled by stage k.
    function automatic logic [5:0] stage_mask(input int k);
        logic [5:0] m;
        m = 6'h3f;
        if (STAGES == 2) begin
            m = (k == 0) ? 6'h07 : 6'h38;
        end else if (STAGES == 3) begin
            case (k)
                0:       m = 6'h03;
                1:       m = 6'h0c;
                default: m = 6'h30;
            endcase
        end
        return m;
    endfunction

    // Partial shifts compose; narrow ops keep the value in bits [31:0] with zeros above.
    function automatic logic [63:0] part_shift(input logic [63:0] a, input logic [2:0] op,
                                               input logic narrow, input logic [5:0] amt);
        logic [63:0] r;
        logic [31:0] a32;
        logic [31:0] r32;
        r   = a;
        a32 = a[31:0];
        r32 = a32;
        if (narrow) begin
            case (op)
                3'b000:  r32 = a32 << amt[4:0];
                3'b001:  r32 = a32 >> amt[4:0];
                3'b010:  r32 = 32'($signed(a32) >>> amt[4:0]);
                3'b011:  r32 = (a32 << amt[4:0]) | (a32 >> (6'd32 - {1'b0, amt[4:0]}));
                3'b100:  r32 = (a32 >> amt[4:0]) | (a32 << (6'd32 - {1'b0, amt[4:0]}));
                default: r32 = a32;
            endcase
            r = {32'b0, r32};
        end else begin
            case (op)
                3'b000:  r = a << amt;
                3'b001:  r = a >> amt;
                3'b010:  r = 64'($signed(a) >>> amt);
                3'b011:  r = (a << amt) | (a >> (7'd64 - {1'b0, amt}));
                3'b100:  r = (a >> amt) | (a << (7'd64 - {1'b0, amt}));
                default: r = a;
            endcase
        end
        return r;
    endfunction

    function automatic logic [63:0] finalize(input logic [63:0] r, input logic [2:0] op,
                                             input logic narrow);
        logic [63:0] f;
        f = r;
        if (op > 3'b100) begin
            f = '0;
        end else if (narrow) begin
            f = {{32{r[31]}}, r[31:0]};
        end
        return f;
    endfunction

    logic            en;
    logic            narrow_in;
    logic [5:0]      shamt_in;
    logic            unused_bits;

    logic            s_v   [STAGES];
    logic [XLEN-1:0] s_val [STAGES];
    logic [2:0]      s_op  [STAGES];
    logic            s_w   [STAGES];
    logic [5:0]      s_sh  [STAGES];
    logic [RDW-1:0]  s_rd  [STAGES];

    logic            src_v   [STAGES];
    logic [XLEN-1:0] src_val [STAGES];
    logic [2:0]      src_op  [STAGES];
    logic            src_w   [STAGES];
    logic [5:0]      src_sh  [STAGES];
    logic [RDW-1:0]  src_rd  [STAGES];
    logic [XLEN-1:0] nxt_val [STAGES];
    logic [5:0]      nxt_sh  [STAGES];

    assign out_valid = s_v[STAGES-1];
    assign out_res   = s_val[STAGES-1];
    assign out_rd    = s_rd[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    assign narrow_in = (XLEN == 32) || in_is32w;
    assign shamt_in  = narrow_in ? {1'b0, in_op2[4:0]} : in_op2[5:0];

    // Upper op2 bits and the final stage's op/shamt copies are never consumed.
    assign unused_bits = ^{in_op2[XLEN-1:6], s_op[STAGES-1], s_w[STAGES-1], s_sh[STAGES-1]};

    always_comb begin
        src_v[0]   = in_valid;
        src_val[0] = in_op1;
        src_op[0]  = in_op;
        src_w[0]   = narrow_in;
        src_sh[0]  = shamt_in;
        src_rd[0]  = in_rd;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = s_v[k-1];
            src_val[k] = s_val[k-1];
            src_op[k]  = s_op[k-1];
            src_w[k]   = s_w[k-1];
            src_sh[k]  = s_sh[k-1];
            src_rd[k]  = s_rd[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (k == STAGES - 1) begin
                nxt_val[k] = XLEN'(finalize(part_shift(64'(src_val[k]), src_op[k], src_w[k],
                                                       src_sh[k] & stage_mask(k)),
                                            src_op[k], src_w[k]));
            end else begin
                nxt_val[k] = XLEN'(part_shift(64'(src_val[k]), src_op[k], src_w[k],
                                              src_sh[k] & stage_mask(k)));
            end
            nxt_sh[k] = src_sh[k] & ~stage_mask(k);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                s_v[k]   <= 1'b0;
                s_val[k] <= '0;
                s_op[k]  <= '0;
                s_w[k]   <= 1'b0;
                s_sh[k]  <= '0;
                s_rd[k]  <= '0;
            end
        end else begin
            if (en) begin
                for (int k = 0; k < STAGES; k++) begin
                    s_v[k]   <= src_v[k];
                    s_val[k] <= nxt_val[k];
                    s_op[k]  <= src_op[k];
                    s_w[k]   <= src_w[k];
                    s_sh[k]  <= nxt_sh[k];
                    s_rd[k]  <= src_rd[k];
                end
            end
            // Flush wins over both advance and hold.
            if (flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    s_v[k] <= 1'b0;
                end
            end
        end
    end

endmodule
